// File: rtl/encoder83_debounce_pkg.sv
// ---------------------------------------------------------------------------
// encoder83_debounce_pkg
// Shared widths and FSM state encodings for the debounced 8-to-3 priority
// encoder slice. Imported by encoder83_debounce and pri_enc83.
// ---------------------------------------------------------------------------
package encoder83_debounce_pkg;

    localparam int IN_W   = 8;
    localparam int CODE_W = 3;

    // STABLE: committed pattern matches the synchronized input.
    // FILTER: a different pattern is being timed before it may be committed.
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_FILTER = 1'b1
    } state_t;

endpackage

// File: rtl/encoder83_debounce_pri_enc.sv
// ---------------------------------------------------------------------------
// pri_enc83
// Purely combinational 8-to-3 priority encoder with presence and multi-hot
// flags.
// Ports:
//   pattern : 8-bit input pattern, bit i maps to code i
//   code    : index of the highest set bit, 0 when no bit is set
//   valid   : at least one bit set
//   multi   : more than one bit set
// ---------------------------------------------------------------------------
module pri_enc83
    import encoder83_debounce_pkg::*;
(
    input  logic [IN_W-1:0]   pattern,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi
);

    logic [3:0] ones;

    // Scan from bit 0 upwards so the highest set bit is the last one written
    // and therefore wins; the same pass counts set bits for the multi flag.
    always_comb begin
        code = '0;
        ones = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (pattern[i]) begin
                code = CODE_W'(i);
            end
            ones = ones + {3'b000, pattern[i]};
        end
        valid = |pattern;
        multi = (ones > 4'd1);
    end

endmodule

// File: rtl/encoder83_debounce.sv
// ---------------------------------------------------------------------------
// encoder83_debounce
// Synchronizes and debounces 8 raw input lines, then priority-encodes the
// committed pattern into registered outputs.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   in        : raw asynchronous input lines (bit i -> code i)
//   code      : highest set bit of the debounced pattern, 0 when none
//   valid     : debounced pattern is non-zero
//   multi     : debounced pattern has more than one bit set
//   code_stb  : one-cycle pulse on the cycle code/valid/multi update
// A new pattern must be seen unchanged for CNT_MAX+1 synchronized samples
// before it is committed.
// ---------------------------------------------------------------------------
module encoder83_debounce
    import encoder83_debounce_pkg::*;
#(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [IN_W-1:0]   in,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi,
    output logic              code_stb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic [IN_W-1:0]   s1;
    logic [IN_W-1:0]   s2;

    state_t            state_q,  state_d;
    logic [IN_W-1:0]   cand_q,   cand_d;
    logic [IN_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [CODE_W-1:0] code_q,   code_d;
    logic              valid_q,  valid_d;
    logic              multi_q,  multi_d;
    logic              stb_q,    stb_d;

    logic [CODE_W-1:0] enc_code;
    logic              enc_valid;
    logic              enc_multi;

    // The encoder watches the candidate so its result is ready to be
    // registered on the very edge the candidate is committed.
    pri_enc83 u_pri_enc (
        .pattern (cand_q),
        .code    (enc_code),
        .valid   (enc_valid),
        .multi   (enc_multi)
    );

    // Two-flop synchronizer per line; only s2 is safe to use downstream.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // All FSM state, the filter counter and the output registers update
    // together, so a commit moves code/valid/multi/code_stb on one edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_STABLE;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            stb_q    <= stb_d;
        end
    end

    // Debounce FSM. In FILTER the checks run in priority order: a bounce back
    // to the committed pattern abandons the filter, a further change restarts
    // it, and only a full run of identical samples commits the candidate.
    // The strobe defaults low so it can only ever last one cycle.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        valid_d  = valid_q;
        multi_d  = multi_q;
        stb_d    = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s2 != stable_q) begin
                    cand_d  = s2;
                    cnt_d   = '0;
                    state_d = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (s2 == stable_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (s2 != cand_q) begin
                    cand_d = s2;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = cand_q;
                    code_d   = enc_code;
                    valid_d  = enc_valid;
                    multi_d  = enc_multi;
                    stb_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign multi    = multi_q;
    assign code_stb = stb_q;

endmodule

// File: tb/tb_encoder83_debounce.sv
// ---------------------------------------------------------------------------
// tb_encoder83_debounce
// Directed, self-checking bench for encoder83_debounce with CNT_MAX=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_encoder83_debounce;

    localparam int CNT_MAX = 4;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] in;
    logic [2:0] code;
    logic       valid;
    logic       multi;
    logic       code_stb;

    int total;
    int bad;
    int stb_count;
    int stb_mark;
    logic [2:0] last_stb_code;

    encoder83_debounce #(
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in        (in),
        .code      (code),
        .valid     (valid),
        .multi     (multi),
        .code_stb  (code_stb)
    );

    // Free-running 10 ns clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Strobe monitor: counts every strobe cycle and remembers the code
    // published with the most recent one.
    always @(negedge sys_clk) begin
        if (code_stb === 1'b1) begin
            stb_count++;
            last_stb_code = code;
        end
    end

    // Drive a new raw pattern on the falling edge so the next rising edge
    // is edge 1 for that change.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge sys_clk);
        in = value;
    endtask

    // Advance n clock cycles, ending just after the n-th falling edge.
    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
        end
    endtask

    // One comparison: counts it, and counts and reports it when it differs.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        stb_count = 0;
        last_stb_code = 3'd0;
        in        = 8'hFF;
        sys_rst_n = 1'b0;

        // 1. Reset held with all lines high, then released with all low.
        $display("[TB] reset behaviour");
        waitCycles(10);
        checkOutput("rst_code",  {5'd0, code}, 8'd0);
        checkOutput("rst_valid", {7'd0, valid}, 8'd0);
        checkOutput("rst_multi", {7'd0, multi}, 8'd0);
        checkOutput("rst_stb",   {7'd0, code_stb}, 8'd0);
        in = 8'h00;
        sys_rst_n = 1'b1;
        waitCycles(50);
        checkOutput("post_rst_code",  {5'd0, code}, 8'd0);
        checkOutput("post_rst_valid", {7'd0, valid}, 8'd0);
        checkOutput("post_rst_stbs",  8'(stb_count), 8'd0);

        // 2. Clean step to 8'h04: commit exactly at edge 8.
        $display("[TB] clean single input");
        stb_mark = stb_count;
        applyStimulus(8'h04);
        waitCycles(7);
        checkOutput("e7_code", {5'd0, code}, 8'd0);
        checkOutput("e7_stb",  {7'd0, code_stb}, 8'd0);
        waitCycles(1);
        checkOutput("e8_code",  {5'd0, code}, 8'd2);
        checkOutput("e8_valid", {7'd0, valid}, 8'd1);
        checkOutput("e8_multi", {7'd0, multi}, 8'd0);
        checkOutput("e8_stb",   {7'd0, code_stb}, 8'd1);
        waitCycles(1);
        checkOutput("e9_stb",   {7'd0, code_stb}, 8'd0);
        waitCycles(5);
        checkOutput("clean_stbs", 8'(stb_count - stb_mark), 8'd1);

        // 3. Priority with several bits set, then back to a single bit.
        $display("[TB] priority and multi-hot");
        stb_mark = stb_count;
        applyStimulus(8'b1001_0010);
        waitCycles(12);
        checkOutput("pri_code",  {5'd0, code}, 8'd7);
        checkOutput("pri_valid", {7'd0, valid}, 8'd1);
        checkOutput("pri_multi", {7'd0, multi}, 8'd1);
        checkOutput("pri_stbs",  8'(stb_count - stb_mark), 8'd1);
        stb_mark = stb_count;
        applyStimulus(8'b0000_0010);
        waitCycles(12);
        checkOutput("one_code",  {5'd0, code}, 8'd1);
        checkOutput("one_multi", {7'd0, multi}, 8'd0);
        checkOutput("one_stbs",  8'(stb_count - stb_mark), 8'd1);

        // 4. Bouncing line for 20 cycles, then a steady 8'h08.
        $display("[TB] bounce rejection");
        stb_mark = stb_count;
        for (int t = 0; t < 10; t++) begin
            applyStimulus((t % 2 == 0) ? 8'h01 : 8'h00);
            waitCycles(1);
        end
        checkOutput("bounce_hold_stbs", 8'(stb_count - stb_mark), 8'd0);
        checkOutput("bounce_hold_code", {5'd0, code}, 8'd1);
        applyStimulus(8'h08);
        waitCycles(12);
        checkOutput("bounce_stbs",     8'(stb_count - stb_mark), 8'd1);
        checkOutput("bounce_code",     {5'd0, code}, 8'd3);
        checkOutput("bounce_stb_code", {5'd0, last_stb_code}, 8'd3);

        // 5. Short dropout of a settled 8'h10 is ignored; a real release is not.
        $display("[TB] glitch return");
        stb_mark = stb_count;
        applyStimulus(8'h10);
        waitCycles(12);
        checkOutput("g_settle_code", {5'd0, code}, 8'd4);
        checkOutput("g_settle_stbs", 8'(stb_count - stb_mark), 8'd1);
        stb_mark = stb_count;
        applyStimulus(8'h00);
        waitCycles(2);
        applyStimulus(8'h10);
        waitCycles(12);
        checkOutput("glitch_code",  {5'd0, code}, 8'd4);
        checkOutput("glitch_valid", {7'd0, valid}, 8'd1);
        checkOutput("glitch_stbs",  8'(stb_count - stb_mark), 8'd0);
        stb_mark = stb_count;
        applyStimulus(8'h00);
        waitCycles(12);
        checkOutput("rel_code",  {5'd0, code}, 8'd0);
        checkOutput("rel_valid", {7'd0, valid}, 8'd0);
        checkOutput("rel_stbs",  8'(stb_count - stb_mark), 8'd1);

        // 6. Reset while a change is pending; commit restarts after release.
        $display("[TB] reset mid-filter");
        applyStimulus(8'h08);
        waitCycles(12);
        checkOutput("pre_abort_code", {5'd0, code}, 8'd3);
        applyStimulus(8'h40);
        waitCycles(2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("abort_code",  {5'd0, code}, 8'd0);
        checkOutput("abort_valid", {7'd0, valid}, 8'd0);
        waitCycles(2);
        stb_mark = stb_count;
        sys_rst_n = 1'b1;
        waitCycles(7);
        checkOutput("rr_e7_code", {5'd0, code}, 8'd0);
        checkOutput("rr_e7_stb",  {7'd0, code_stb}, 8'd0);
        waitCycles(1);
        checkOutput("rr_e8_code", {5'd0, code}, 8'd6);
        checkOutput("rr_e8_stb",  {7'd0, code_stb}, 8'd1);
        waitCycles(2);
        checkOutput("rr_stbs", 8'(stb_count - stb_mark), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
